// File: rtl/fetch_pkg.sv
// Shared types for the fetch front end: queue entry layout and fetch FSM states.
package fetch_pkg;

  localparam int FETCH_XLEN = 32;
  localparam int FETCH_ILEN = 32;

  typedef struct packed {
    logic [FETCH_XLEN-1:0] pc;
    logic [FETCH_ILEN-1:0] instr;
  } fetch_entry_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_PUSH,
    S_DROP
  } fetch_state_e;

endpackage

// File: rtl/fetch_compact.sv
// Shifts the valid slots (off..N-1) of a fetch block down onto ports 0..k-1,
// tagging each with its PC; ports at or above k carry zero.
module fetch_compact #(
  parameter int N    = 4,
  parameter int XLEN = 32,
  parameter int ILEN = 32
) (
  input  logic [ILEN-1:0]      i_block   [N],
  input  logic [XLEN-1:0]      i_base,
  input  logic [$clog2(N)-1:0] i_off,
  output logic [XLEN+ILEN-1:0] o_entries [N],
  output logic [0:N-1]         o_mask,
  output logic [$clog2(N):0]   o_k
);

  localparam int OFF_W = $clog2(N);

  assign o_k = (OFF_W+1)'(N) - {1'b0, i_off};

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_port
      logic [OFF_W:0] w_slot;
      logic           w_valid;

      assign w_slot  = {1'b0, i_off} + (OFF_W+1)'(gi);
      assign w_valid = (OFF_W+1)'(gi) < o_k;
      assign o_mask[gi] = w_valid;
      // Slot index wraps for invalid ports, but those are zeroed anyway.
      assign o_entries[gi] = w_valid
          ? {i_base + XLEN'({w_slot, 2'b00}), i_block[w_slot[OFF_W-1:0]]}
          : '0;
    end
  endgenerate

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: one outstanding aligned block request, compacts each response
// onto contiguous queue ports, and flushes/discards on redirect.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int              N        = 4,
  parameter int              XLEN     = 32,
  parameter int              ILEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 redirect_valid,
  input  logic [XLEN-1:0]      redirect_pc,
  output logic                 imem_req_valid,
  input  logic                 imem_req_ready,
  output logic [XLEN-1:0]      imem_req_addr,
  input  logic                 imem_resp_valid,
  input  logic [ILEN-1:0]      imem_resp_data [N],
  output logic [XLEN+ILEN-1:0] fq_wr_data     [N],
  output logic [0:N-1]         fq_wr_en,
  input  logic [0:N-1]         fq_wr_ok,
  output logic                 fq_clr
);

  localparam int              OFF_W       = $clog2(N);
  localparam logic [XLEN-1:0] FETCH_BYTES = XLEN'(N * 4);

  fetch_state_e     reg_fsm;
  logic [XLEN-1:0]  r_pc;
  logic [XLEN-1:0]  r_base;
  logic [OFF_W-1:0] r_off;
  logic [ILEN-1:0]  r_block [N];

  logic [XLEN-1:0]      w_pc_base;
  logic [XLEN-1:0]      w_src_base;
  logic [XLEN-1:0]      w_next_pc;
  logic [ILEN-1:0]      w_src_block [N];
  logic [XLEN+ILEN-1:0] w_entries   [N];
  logic [0:N-1]         w_mask;
  logic [OFF_W:0]       w_k;
  logic                 w_hs;
  logic                 w_push_ok;
  logic                 w_fire;

  assign w_pc_base  = r_pc & ~(FETCH_BYTES - XLEN'(1));
  assign w_hs       = imem_req_valid & imem_req_ready;
  // Base stays at the requested block until a push or redirect moves r_pc.
  assign w_src_base = (reg_fsm == S_PUSH) ? r_base : w_pc_base;
  assign w_next_pc  = w_src_base + FETCH_BYTES;

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_src
      assign w_src_block[gi] = (reg_fsm == S_PUSH) ? r_block[gi] : imem_resp_data[gi];
    end
  endgenerate

  fetch_compact #(
    .N    (N),
    .XLEN (XLEN),
    .ILEN (ILEN)
  ) u_compact (
    .i_block   (w_src_block),
    .i_base    (w_src_base),
    .i_off     (r_off),
    .o_entries (w_entries),
    .o_mask    (w_mask),
    .o_k       (w_k)
  );

  always_comb begin
    w_push_ok = 1'b1;
    for (int i = 0; i < N; i++) begin
      if (((OFF_W+1)'(i) < w_k) && !fq_wr_ok[i]) w_push_ok = 1'b0;
    end
  end

  assign w_fire = !redirect_valid && w_push_ok &&
                  (((reg_fsm == S_WAIT) && imem_resp_valid) || (reg_fsm == S_PUSH));

  assign imem_req_valid = (reg_fsm == S_REQ);
  assign imem_req_addr  = imem_req_valid ? w_pc_base : '0;
  assign fq_clr         = redirect_valid & rst_n;
  assign fq_wr_en       = w_fire ? w_mask : '0;

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_out
      assign fq_wr_data[gi] = fq_wr_en[gi] ? w_entries[gi] : '0;
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      reg_fsm <= S_IDLE;
      r_pc    <= RESET_PC;
      r_base  <= '0;
      r_off   <= '0;
      for (int i = 0; i < N; i++) r_block[i] <= '0;
    end else begin
      case (reg_fsm)
        S_IDLE: begin
          if (redirect_valid) r_pc <= redirect_pc;
          reg_fsm <= S_REQ;
        end
        S_REQ: begin
          if (redirect_valid) begin
            r_pc    <= redirect_pc;
            reg_fsm <= w_hs ? S_DROP : S_REQ;
          end else if (w_hs) begin
            r_off   <= r_pc[OFF_W+1:2];
            reg_fsm <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (redirect_valid) begin
            r_pc    <= redirect_pc;
            reg_fsm <= imem_resp_valid ? S_REQ : S_DROP;
          end else if (imem_resp_valid) begin
            if (w_push_ok) begin
              r_pc    <= w_next_pc;
              reg_fsm <= S_REQ;
            end else begin
              for (int i = 0; i < N; i++) r_block[i] <= imem_resp_data[i];
              r_base  <= w_pc_base;
              reg_fsm <= S_PUSH;
            end
          end
        end
        S_PUSH: begin
          if (redirect_valid) begin
            r_pc    <= redirect_pc;
            reg_fsm <= S_REQ;
          end else if (w_push_ok) begin
            r_pc    <= w_next_pc;
            reg_fsm <= S_REQ;
          end
        end
        S_DROP: begin
          if (redirect_valid) r_pc <= redirect_pc;
          else if (imem_resp_valid) reg_fsm <= S_REQ;
        end
        default: reg_fsm <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit (N=4): vector table of redirect targets plus hand-written
// multi-cycle sequences; queue writes are checked against a scoreboard.
module tb_fetch_unit;
  import fetch_pkg::*;

  localparam int N    = 4;
  localparam int XLEN = 32;
  localparam int ILEN = 32;

  logic        clk;
  logic        rst_n;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data [N];
  logic [63:0] fq_wr_data     [N];
  logic [0:3]  fq_wr_en;
  logic [0:3]  fq_wr_ok;
  logic        fq_clr;

  fetch_unit #(
    .N        (N),
    .XLEN     (XLEN),
    .ILEN     (ILEN),
    .RESET_PC (32'h0000_0100)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .fq_wr_data      (fq_wr_data),
    .fq_wr_en        (fq_wr_en),
    .fq_wr_ok        (fq_wr_ok),
    .fq_clr          (fq_clr)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int           n_total = 0;
  int           n_pass  = 0;
  int           outstanding = 0;
  fetch_entry_t exp_q[$];
  logic [31:0]  blk [N];

  typedef struct {
    logic [31:0] target;
    logic [3:0]  ok;
    logic [3:0]  exp_en;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h required %h", name, got, exp);
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  function automatic logic [3:0] mask_of(input int k);
    logic [3:0] m;
    m = 4'hF;
    return m << (4 - k);
  endfunction

  task automatic rand_block();
    for (int i = 0; i < N; i++) blk[i] = $urandom;
    imem_resp_data = blk;
  endtask

  // Expected queue entries for a response of base/off, in port order.
  task automatic push_expected(input logic [31:0] base, input int off);
    fetch_entry_t e;
    for (int j = off; j < N; j++) begin
      e.pc    = base + 32'(4 * j);
      e.instr = blk[j];
      exp_q.push_back(e);
    end
  endtask

  // From S_REQ with ready low: pulse a redirect, then show the new request.
  task automatic redirect_and_req(input logic [31:0] target);
    tick();
    redirect_valid  = 1'b1;
    redirect_pc     = target;
    imem_req_ready  = 1'b0;
    imem_resp_valid = 1'b0;
    #2;
    chk("redir_clr", 64'(fq_clr), 64'd1);
    chk("redir_no_write", 64'(fq_wr_en), 64'd0);
    tick();
    redirect_valid = 1'b0;
    imem_req_ready = 1'b1;
    #2;
    chk("redir_req_valid", 64'(imem_req_valid), 64'd1);
    chk("redir_req_addr", 64'(imem_req_addr), 64'(target & ~32'hF));
  endtask

  // Monitor: queue writes against scoreboard, single-outstanding-request rule.
  always @(negedge clk) begin
    #4;
    if (!rst_n) begin
      outstanding = 0;
    end else begin
      if (imem_req_valid) chk("single_outstanding", 64'(outstanding), 64'd0);
      if (imem_req_valid && imem_req_ready) outstanding++;
      if (imem_resp_valid) outstanding--;
    end
    if (fq_wr_en != 4'b0000) begin
      for (int i = 0; i < N; i++) begin
        if (fq_wr_en[i]) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_write", 64'd1, 64'd0);
          end else begin
            fetch_entry_t e;
            e = exp_q.pop_front();
            $display("write port %0d pc=%h instr=%h", i, fq_wr_data[i][63:32], fq_wr_data[i][31:0]);
            chk("wr_pc", 64'(fq_wr_data[i][63:32]), 64'(e.pc));
            chk("wr_instr", 64'(fq_wr_data[i][31:0]), 64'(e.instr));
          end
        end else begin
          chk("unused_port_data", fq_wr_data[i], 64'd0);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t vecs [6];
    logic [31:0] base;
    int off, k;
    logic [3:0] m;
    logic blocked;

    vecs[0] = '{32'h0000_0208, 4'b1111, 4'b1100};
    vecs[1] = '{32'h0000_0304, 4'b1111, 4'b1110};
    vecs[2] = '{32'h0000_040C, 4'b1000, 4'b1000};
    vecs[3] = '{32'h0000_050C, 4'b0000, 4'b0000};
    vecs[4] = '{32'h0000_0600, 4'b1110, 4'b0000};
    vecs[5] = '{32'h0000_0704, 4'b1110, 4'b1110};

    rst_n           = 1'b0;
    redirect_valid  = 1'b0;
    redirect_pc     = '0;
    imem_req_ready  = 1'b0;
    imem_resp_valid = 1'b0;
    fq_wr_ok        = 4'b1111;
    for (int i = 0; i < N; i++) blk[i] = '0;
    imem_resp_data = blk;

    // Reset state
    repeat (2) tick();
    #2;
    chk("rst_req_valid", 64'(imem_req_valid), 64'd0);
    chk("rst_req_addr", 64'(imem_req_addr), 64'd0);
    chk("rst_wr_en", 64'(fq_wr_en), 64'd0);
    chk("rst_clr", 64'(fq_clr), 64'd0);
    chk("rst_wr_data0", fq_wr_data[0], 64'd0);

    // Release: one idle cycle, then request at RESET_PC and bypass push
    tick();
    rst_n = 1'b1;
    #2;
    chk("idle_req_valid", 64'(imem_req_valid), 64'd0);
    tick();
    imem_req_ready = 1'b1;
    #2;
    chk("first_req_valid", 64'(imem_req_valid), 64'd1);
    chk("first_req_addr", 64'(imem_req_addr), 64'h100);
    tick();
    imem_req_ready  = 1'b0;
    blk = '{32'hAAAA_0001, 32'hBBBB_0002, 32'hCCCC_0003, 32'hDDDD_0004};
    imem_resp_data  = blk;
    imem_resp_valid = 1'b1;
    push_expected(32'h100, 0);
    #2;
    chk("bypass_wr_en", 64'(fq_wr_en), 64'(4'b1111));
    tick();
    imem_resp_valid = 1'b0;
    #2;
    chk("next_req_addr", 64'(imem_req_addr), 64'h110);

    // Vector table: redirect target sets offset, wr_ok pattern decides bypass vs push
    for (int v = 0; v < 6; v++) begin
      redirect_and_req(vecs[v].target);
      off  = int'(vecs[v].target[3:2]);
      base = vecs[v].target & ~32'hF;
      k    = N - off;
      m    = mask_of(k);
      tick();
      imem_req_ready  = 1'b0;
      rand_block();
      imem_resp_valid = 1'b1;
      fq_wr_ok        = vecs[v].ok;
      blocked         = ((vecs[v].ok & m) != m);
      if (!blocked) push_expected(base, off);
      #2;
      chk("tbl_wr_en", 64'(fq_wr_en), 64'(vecs[v].exp_en));
      if (blocked) begin
        tick();
        imem_resp_valid = 1'b0;
        fq_wr_ok        = 4'b1111;
        push_expected(base, off);
        #2;
        chk("tbl_push_en", 64'(fq_wr_en), 64'(m));
      end
      tick();
      imem_resp_valid = 1'b0;
      #2;
      chk("tbl_next_valid", 64'(imem_req_valid), 64'd1);
      chk("tbl_next_addr", 64'(imem_req_addr), 64'(base + 32'h10));
    end

    // Blocked for three cycles, then one full push, no duplicate
    redirect_and_req(32'h0000_0800);
    tick();
    imem_req_ready  = 1'b0;
    rand_block();
    imem_resp_valid = 1'b1;
    fq_wr_ok        = 4'b1000;
    #2;
    chk("stall_resp_en", 64'(fq_wr_en), 64'd0);
    repeat (2) begin
      tick();
      imem_resp_valid = 1'b0;
      #2;
      chk("stall_hold_en", 64'(fq_wr_en), 64'd0);
      chk("stall_no_req", 64'(imem_req_valid), 64'd0);
    end
    tick();
    fq_wr_ok = 4'b1111;
    push_expected(32'h800, 0);
    #2;
    chk("stall_push_en", 64'(fq_wr_en), 64'(4'b1111));
    tick();
    #2;
    chk("stall_no_dup", 64'(fq_wr_en), 64'd0);
    chk("stall_next_addr", 64'(imem_req_addr), 64'h810);

    // Redirect in S_WAIT before the response
    tick();
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_090C;
    #2;
    chk("wait_redir_clr", 64'(fq_clr), 64'd1);
    tick();
    redirect_valid = 1'b0;
    #2;
    chk("drop_no_req", 64'(imem_req_valid), 64'd0);
    tick();
    rand_block();
    imem_resp_valid = 1'b1;
    #2;
    chk("drop_no_write", 64'(fq_wr_en), 64'd0);
    tick();
    imem_resp_valid = 1'b0;
    #2;
    chk("drop_next_valid", 64'(imem_req_valid), 64'd1);
    chk("drop_next_addr", 64'(imem_req_addr), 64'h900);

    // Redirect in the handshake cycle
    tick();
    imem_req_ready = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0A04;
    #2;
    chk("hs_redir_clr", 64'(fq_clr), 64'd1);
    chk("hs_redir_no_write", 64'(fq_wr_en), 64'd0);
    tick();
    imem_req_ready = 1'b0;
    redirect_valid = 1'b0;
    #2;
    chk("hs_drop_no_req", 64'(imem_req_valid), 64'd0);
    tick();
    rand_block();
    imem_resp_valid = 1'b1;
    #2;
    chk("hs_drop_no_write", 64'(fq_wr_en), 64'd0);
    tick();
    imem_resp_valid = 1'b0;
    #2;
    chk("hs_next_addr", 64'(imem_req_addr), 64'hA00);

    // Redirect in the response cycle
    tick();
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready  = 1'b0;
    rand_block();
    imem_resp_valid = 1'b1;
    redirect_valid  = 1'b1;
    redirect_pc     = 32'h0000_0B08;
    #2;
    chk("resp_redir_clr", 64'(fq_clr), 64'd1);
    chk("resp_redir_no_write", 64'(fq_wr_en), 64'd0);
    tick();
    imem_resp_valid = 1'b0;
    redirect_valid  = 1'b0;
    #2;
    chk("resp_next_valid", 64'(imem_req_valid), 64'd1);
    chk("resp_next_addr", 64'(imem_req_addr), 64'hB00);

    // PC wrap through S_PUSH
    redirect_and_req(32'hFFFF_FFF0);
    tick();
    imem_req_ready  = 1'b0;
    rand_block();
    imem_resp_valid = 1'b1;
    fq_wr_ok        = 4'b0000;
    #2;
    chk("wrap_block_en", 64'(fq_wr_en), 64'd0);
    tick();
    imem_resp_valid = 1'b0;
    fq_wr_ok        = 4'b1111;
    push_expected(32'hFFFF_FFF0, 0);
    #2;
    chk("wrap_push_en", 64'(fq_wr_en), 64'(4'b1111));
    tick();
    #2;
    chk("wrap_next_addr", 64'(imem_req_addr), 64'h0);

    // Async reset while parked in S_PUSH
    redirect_and_req(32'h0000_0C00);
    tick();
    imem_req_ready  = 1'b0;
    rand_block();
    imem_resp_valid = 1'b1;
    fq_wr_ok        = 4'b0000;
    tick();
    imem_resp_valid = 1'b0;
    #2;
    chk("push_park_en", 64'(fq_wr_en), 64'd0);
    #1;
    rst_n    = 1'b0;
    fq_wr_ok = 4'b1111;
    #1;
    chk("arst_req_valid", 64'(imem_req_valid), 64'd0);
    chk("arst_req_addr", 64'(imem_req_addr), 64'd0);
    chk("arst_wr_en", 64'(fq_wr_en), 64'd0);
    chk("arst_clr", 64'(fq_clr), 64'd0);
    chk("arst_wr_data0", fq_wr_data[0], 64'd0);
    tick();
    rst_n = 1'b1;
    #2;
    chk("arst_idle", 64'(imem_req_valid), 64'd0);
    tick();
    #2;
    chk("arst_req_again", 64'(imem_req_valid), 64'd1);
    chk("arst_req_addr_again", 64'(imem_req_addr), 64'h100);

    tick();
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
